// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and optional multi-cycle MULT/DIV.
// Define ALU_CTRL_MULDIV_EN to build the MULT/DIV decode, the BUSY state and the issue counter.
module alu_ctrl_seq #(
    parameter int OPW           = 4,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     AluOp,
    input  logic [5:0]     functionField,
    input  logic [2:0]     immOp,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] operation,
    output logic           illegal,
    output logic           busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [OPW-1:0] NOP_EXT = OPW'(OP_NOP);

`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [3:0] OP_MULT = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam int CW = $clog2(MULDIV_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, VALID = 2'd2} state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_multi;
`else
    typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_e;
`endif

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           ill_q, ill_d;
    logic [3:0]     dec_op;
    logic           dec_ill;
    logic           accept;

    always_comb begin
        dec_op  = OP_NOP;
        dec_ill = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
        dec_multi = 1'b0;
`endif
        unique case (AluOp)
            2'b00: begin dec_op = OP_ADD; dec_ill = 1'b0; end
            2'b01: begin dec_op = OP_SUB; dec_ill = 1'b0; end
            2'b10: begin
                dec_ill = 1'b0;
                case (functionField)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b101010: dec_op = OP_SLT;
                    6'b101011: dec_op = OP_SLTU;
                    6'b000000: dec_op = OP_NOP;
                    6'b000010: dec_op = OP_SRL;
                    6'b000011: dec_op = OP_SRA;
                    6'b000100: dec_op = OP_SLL;
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000: begin dec_op = OP_MULT; dec_multi = 1'b1; end
                    6'b011010: begin dec_op = OP_DIV;  dec_multi = 1'b1; end
`endif
                    default: begin dec_op = OP_NOP; dec_ill = 1'b1; end
                endcase
            end
            2'b11: begin
                dec_ill = 1'b0;
                case (immOp)
                    3'b000: dec_op = OP_ADD;
                    3'b001: dec_op = OP_SLT;
                    3'b010: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_AND;
                    3'b101: dec_op = OP_OR;
                    3'b110: dec_op = OP_XOR;
                    default: begin dec_op = OP_NOP; dec_ill = 1'b1; end
                endcase
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == VALID) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == VALID);
    assign operation = op_q;
    assign illegal   = ill_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ill_d   = ill_q;
`ifdef ALU_CTRL_MULDIV_EN
        cnt_d   = cnt_q;
`endif
        if (accept) begin
            op_d    = OPW'(dec_op);
            ill_d   = dec_ill;
            state_d = VALID;
`ifdef ALU_CTRL_MULDIV_EN
            if (dec_multi) begin
                state_d = BUSY;
                cnt_d   = CW'(MULDIV_CYCLES - 1);
            end
`endif
        end else begin
            case (state_q)
                VALID: if (out_ready) state_d = IDLE;
`ifdef ALU_CTRL_MULDIV_EN
                // Result becomes visible once the issue counter has run out.
                BUSY: begin
                    if (cnt_q == '0) state_d = VALID;
                    else             cnt_d   = cnt_q - 1'b1;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

`ifdef ALU_CTRL_MULDIV_EN
    assign busy = (state_q == BUSY);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= NOP_EXT;
            ill_q   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
`ifdef ALU_CTRL_MULDIV_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed + randomized bench for alu_ctrl_seq with a result scoreboard.
// MULT/DIV checks follow ALU_CTRL_MULDIV_EN.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] AluOp;
    logic [5:0] functionField;
    logic [2:0] immOp;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] operation;
    logic       illegal;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    alu_ctrl_seq #(.OPW(4), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .AluOp(AluOp), .functionField(functionField), .immOp(immOp),
        .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
        .illegal(illegal), .busy(busy)
    );

    // Returns {multi, illegal, op}
    function automatic logic [5:0] model(input logic [1:0] a, input logic [5:0] f,
                                         input logic [2:0] im);
        logic [5:0] r;
        r = {2'b01, 4'b1000};
        case (a)
            2'b00: r = {2'b00, 4'b0010};
            2'b01: r = {2'b00, 4'b0110};
            2'b10: case (f)
                6'b100000: r = {2'b00, 4'b0010};
                6'b100010: r = {2'b00, 4'b0110};
                6'b100100: r = {2'b00, 4'b0000};
                6'b100101: r = {2'b00, 4'b0001};
                6'b100110: r = {2'b00, 4'b0011};
                6'b100111: r = {2'b00, 4'b0100};
                6'b101010: r = {2'b00, 4'b0111};
                6'b101011: r = {2'b00, 4'b1101};
                6'b000000: r = {2'b00, 4'b1000};
                6'b000010: r = {2'b00, 4'b1001};
                6'b000011: r = {2'b00, 4'b1010};
                6'b000100: r = {2'b00, 4'b0101};
`ifdef ALU_CTRL_MULDIV_EN
                6'b011000: r = {2'b10, 4'b1011};
                6'b011010: r = {2'b10, 4'b1100};
`endif
                default:   r = {2'b01, 4'b1000};
            endcase
            default: case (im)
                3'b000: r = {2'b00, 4'b0010};
                3'b001: r = {2'b00, 4'b0111};
                3'b010: r = {2'b00, 4'b1101};
                3'b100: r = {2'b00, 4'b0000};
                3'b101: r = {2'b00, 4'b0001};
                3'b110: r = {2'b00, 4'b0011};
                default: r = {2'b01, 4'b1000};
            endcase
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [5:0] m;
        logic [4:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", {27'd0, illegal, operation}, {27'd0, e});
            end
        end
        if (rst_n && in_valid && in_ready) begin
            m = model(AluOp, functionField, immOp);
            sb.push_back(m[4:0]);
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] rtab [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b101010, 6'b101011,
                              6'b000000, 6'b000010, 6'b000011, 6'b000100,
                              6'b111111, 6'b010101};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        AluOp = 2'b00; functionField = 6'd0; immOp = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_operation", 32'(operation), 32'h8);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // SUB via R-type, latency 1
        in_valid = 1'b1; AluOp = 2'b10; functionField = 6'b100010;
        tick();
        in_valid = 1'b0;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_op", 32'(operation), 32'h6);
        chk("sub_ill", 32'(illegal), 32'd0);
        tick();
        chk("idle_after_drain", 32'(out_valid), 32'd0);

        // Undefined funct
        in_valid = 1'b1; functionField = 6'b111111;
        tick();
        in_valid = 1'b0;
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_op", 32'(operation), 32'h8);
        chk("bad_ill", 32'(illegal), 32'd1);
        tick();

        // Back-to-back stream
        in_valid = 1'b1; AluOp = 2'b00;
        tick();
        chk("stream0_op", 32'(operation), 32'h2);
        AluOp = 2'b01;
        tick();
        chk("stream1_valid", 32'(out_valid), 32'd1);
        chk("stream1_op", 32'(operation), 32'h6);
        AluOp = 2'b11; immOp = 3'b101;
        tick();
        chk("stream2_valid", 32'(out_valid), 32'd1);
        chk("stream2_op", 32'(operation), 32'h1);
        in_valid = 1'b0;
        tick();
        chk("stream_end", 32'(out_valid), 32'd0);

        // Full R-type and immediate tables, back-to-back
        in_valid = 1'b1; AluOp = 2'b10;
        for (int i = 0; i < 14; i++) begin
            functionField = rtab[i];
            tick();
        end
        AluOp = 2'b11;
        for (int i = 0; i < 8; i++) begin
            immOp = 3'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Stall: result held while consumer is not ready
        out_ready = 1'b0; in_valid = 1'b1; AluOp = 2'b10; functionField = 6'b100110;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_op", 32'(operation), 32'h3);
            in_valid = ~in_valid;
            functionField = 6'($urandom_range(63));
            tick();
        end
        chk("stall_op_end", 32'(operation), 32'h3);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // MULT
        in_valid = 1'b1; AluOp = 2'b10; functionField = 6'b011000;
        tick();
`ifdef ALU_CTRL_MULDIV_EN
        for (int i = 0; i < 4; i++) begin
            chk("mult_busy", 32'(busy), 32'd1);
            chk("mult_in_ready", 32'(in_ready), 32'd0);
            chk("mult_no_valid", 32'(out_valid), 32'd0);
            chk("mult_op_hold", 32'(operation), 32'hb);
            in_valid = (i < 3) ? ~in_valid : 1'b0;
            functionField = 6'b100000;
            tick();
        end
        chk("mult_valid", 32'(out_valid), 32'd1);
        chk("mult_busy_done", 32'(busy), 32'd0);
        chk("mult_op", 32'(operation), 32'hb);
        chk("mult_ill", 32'(illegal), 32'd0);
`else
        in_valid = 1'b0;
        chk("mult_off_valid", 32'(out_valid), 32'd1);
        chk("mult_off_ill", 32'(illegal), 32'd1);
        chk("mult_off_op", 32'(operation), 32'h8);
        chk("mult_off_busy", 32'(busy), 32'd0);
`endif
        in_valid = 1'b0;
        tick();

        // Reset with a result pending
        in_valid = 1'b1; functionField = 6'b011010;
        tick();
        in_valid = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        tick();
        chk("div_busy2", 32'(busy), 32'd1);
`endif
        rst_n = 1'b0;
        tick();
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_op", 32'(operation), 32'h8);
        chk("rst2_ill", 32'(illegal), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst2_no_valid", 32'(out_valid), 32'd0);
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            AluOp = 2'($urandom_range(3));
            functionField = ($urandom_range(1) != 0) ? rtab[$urandom_range(13)]
                                                     : 6'($urandom_range(63));
            immOp = 3'($urandom_range(7));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !out_valid && !busy) break;
            tick();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OPW, default 4, width of operation code; SHALL be >= 4, with upper bits zero-filled.
REQ-002 Parameter MULDIV_CYCLES, default 32, issue latency of MULT/DIV; SHALL be >= 2.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port in_valid  input  1  decode request present.
REQ-006 Port in_ready  output  1  block can accept request this cycle.
REQ-007 Port AluOp  input  2  class from control unit: 00 load/store, 01 branch, 10 R-type, 11 immediate.
REQ-008 Port functionField  input  6  instruction funct field.
REQ-009 Port immOp  input  3  immediate sub-op, used only when AluOp=11.
REQ-010 Port out_valid  output  1  operation holds a decoded result.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port operation  output  OPW  decoded ALU operation.
REQ-013 Port illegal  output  1  current result came from an undefined encoding.
REQ-014 Port busy  output  1  multi-cycle MULT/DIV in progress.

Function
REQ-015 Codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLL 0101, SUB 0110, SLT 0111, NOP 1000, SRL 1001, SRA 1010, MULT 1011, DIV 1100, SLTU 1101.
REQ-016 AluOp=00 SHALL decode ADD; AluOp=01 SHALL decode SUB; functionField ignored.
REQ-017 AluOp=10 funct map SHALL be: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 NOP, 000010 SRL, 000011 SRA, 000100 SLL; 011000 MULT and 011010 DIV per REQ-035/036.
REQ-018 AluOp=11 immOp map SHALL be: 000 ADD, 001 SLT, 010 SLTU, 100 AND, 101 OR, 110 XOR.
REQ-019 Any unmapped encoding SHALL yield operation=NOP with illegal=1; otherwise illegal=0. No previous value is ever retained.
REQ-020 FSM states SHALL be IDLE, BUSY and VALID.
REQ-021 In IDLE, in_ready=1 and out_valid=0.
REQ-022 In BUSY, in_ready=0, out_valid=0 and busy=1.
REQ-023 In VALID, out_valid=1 and in_ready=out_ready.
REQ-024 A transfer SHALL occur when in_valid and in_ready are both 1; operation and illegal SHALL be registered on that edge.
REQ-025 A single-cycle op SHALL go to VALID on the accepting edge: latency 1 cycle.
REQ-026 MULT/DIV SHALL go to BUSY with the counter loaded to MULDIV_CYCLES-1, decrementing each cycle; at counter=0 the FSM SHALL go to VALID, so out_valid rises MULDIV_CYCLES cycles after acceptance.
REQ-027 During BUSY, operation SHALL be held stable and in_valid ignored.
REQ-028 In VALID with out_ready=1 and in_valid=1, the new request SHALL be accepted in the same cycle (back-to-back, no bubble).
REQ-029 In VALID with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE; out_valid=0 on the next cycle.
REQ-030 In VALID with out_ready=0, operation and illegal SHALL be held unchanged.
REQ-031 Inputs SHALL be sampled only on transfer; changes at other times have no effect.

Reset
REQ-032 When rst_n=0 at a rising edge, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-033 On reset, out_valid=0, busy=0, illegal=0 and operation=NOP (0...01000) on the next cycle.
REQ-034 Reset asserted in BUSY or VALID SHALL discard the pending result; no out_valid follows.

Configuration
REQ-035 With macro ALU_CTRL_MULDIV_EN defined, funct 011000 SHALL decode MULT and 011010 DIV, both multi-cycle, and BUSY and the counter exist.
REQ-036 Without ALU_CTRL_MULDIV_EN, these functs SHALL be illegal (NOP, latency 1), busy SHALL be tied 0, and BUSY and the counter SHALL not be built.

Verification
REQ-037 Reset then AluOp=10, funct=100010, in_valid=1 -> next cycle out_valid=1, operation=0110, illegal=0.
REQ-038 AluOp=10, funct=111111 -> operation=1000, illegal=1, with out_valid the next cycle.
REQ-039 out_ready=1, stream AluOp=00, 01, 11/immOp=101 on consecutive cycles -> operation 0010, 0110, 0001 on consecutive cycles, with no bubble.
REQ-040 Macro on, MULDIV_CYCLES=4, funct=011000 -> busy=1 for 4 cycles, in_ready=0, then out_valid=1, operation=1011; macro off -> illegal=1 after 1 cycle.
REQ-041 out_ready=0 for 3 cycles while in_valid toggles and funct changes -> operation unchanged, in_ready=0.
REQ-042 rst_n=0 on the 2nd BUSY cycle -> next cycle busy=0, out_valid=0, operation=1000, and no later out_valid.
